// File: rtl/video_mode_ctrl.sv
// Video mode change sequencer for the HDMI transmit path.
// Takes step / direct mode requests, blanks the pattern generator across a
// frame boundary, commits the new mode, kicks a pixel-PLL reconfiguration
// and waits for lock. If lock never arrives it falls back to the old mode.
module video_mode_ctrl #(
    parameter int NUM_MODES     = 10,
    parameter int DEFAULT_MODE  = 0,
    parameter int LOCK_MIN      = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       next_req,
    input  logic       load_req,
    input  logic [3:0] load_mode,
    input  logic       frame_start,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       pll_reconfig,
    output logic       blank,
    output logic       busy,
    output logic       lock_err
);

    localparam logic [3:0]  MODE_LAST   = 4'(NUM_MODES - 1);
    localparam logic [3:0]  MODE_RST    = 4'(DEFAULT_MODE);
    localparam logic [19:0] LOCK_MIN_C  = 20'(LOCK_MIN);
    localparam logic [19:0] LOCK_TO_C   = 20'(LOCK_TIMEOUT);
    localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_BLANK,
        S_RECONFIG,
        S_REVERT,
        S_SETTLE
    } state_t;

    state_t      state, state_d;
    logic [3:0]  mode_d, target, target_d, old_mode, old_mode_d;
    logic [19:0] cnt, cnt_d;
    logic [2:0]  frame_cnt, frame_cnt_d;
    logic        mode_change_d, pll_reconfig_d, blank_d, busy_d, lock_err_d;
    logic        req_ok;
    logic [3:0]  req_target;

    // Request decode: an illegal or no-op load_req also swallows next_req.
    always_comb begin
        req_ok     = 1'b0;
        req_target = mode;
        if (load_req) begin
            req_ok     = (load_mode <= MODE_LAST) && (load_mode != mode);
            req_target = load_mode;
        end else if (next_req) begin
            req_ok     = 1'b1;
            req_target = (mode == MODE_LAST) ? 4'd0 : mode + 4'd1;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d        = state;
        mode_d         = mode;
        target_d       = target;
        old_mode_d     = old_mode;
        cnt_d          = cnt;
        frame_cnt_d    = frame_cnt;
        mode_change_d  = 1'b0;
        pll_reconfig_d = 1'b0;
        blank_d        = blank;
        busy_d         = busy;
        lock_err_d     = lock_err;

        unique case (state)
            S_IDLE: begin
                if (req_ok) begin
                    target_d   = req_target;
                    old_mode_d = mode;
                    lock_err_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_start) begin
                    blank_d = 1'b1;
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (frame_start) begin
                    mode_d         = target;
                    mode_change_d  = 1'b1;
                    pll_reconfig_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_RECONFIG;
                end
            end
            S_RECONFIG, S_REVERT: begin
                cnt_d = cnt + 20'd1;
                if (cnt >= LOCK_MIN_C && pll_locked) begin
                    frame_cnt_d = '0;
                    state_d     = S_SETTLE;
                end else if (cnt == LOCK_TO_C) begin
                    if (state == S_RECONFIG) begin
                        lock_err_d     = 1'b1;
                        mode_d         = old_mode;
                        mode_change_d  = 1'b1;
                        pll_reconfig_d = 1'b1;
                        cnt_d          = '0;
                        state_d        = S_REVERT;
                    end else begin
                        blank_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_SETTLE: begin
                if (frame_start) begin
                    if (frame_cnt == SETTLE_LAST) begin
                        blank_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            mode         <= MODE_RST;
            target       <= MODE_RST;
            old_mode     <= MODE_RST;
            cnt          <= '0;
            frame_cnt    <= '0;
            mode_change  <= 1'b0;
            pll_reconfig <= 1'b0;
            blank        <= 1'b0;
            busy         <= 1'b0;
            lock_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values, independent of statement order.
            state        <= state_d;
            mode         <= mode_d;
            target       <= target_d;
            old_mode     <= old_mode_d;
            cnt          <= cnt_d;
            frame_cnt    <= frame_cnt_d;
            mode_change  <= mode_change_d;
            pll_reconfig <= pll_reconfig_d;
            blank        <= blank_d;
            busy         <= busy_d;
            lock_err     <= lock_err_d;
        end
    end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Self-checking bench for video_mode_ctrl: a table of request vectors plus
// hand-written sequences for lock timing, lock loss, timeout and reset.
module tb_video_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       next_req;
    logic       load_req;
    logic [3:0] load_mode;
    logic       frame_start;
    logic       pll_locked;

    logic [3:0] mode,   t_mode;
    logic       mode_change,  t_mode_change;
    logic       pll_reconfig, t_pll_reconfig;
    logic       blank,  t_blank;
    logic       busy,   t_busy;
    logic       lock_err, t_lock_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clk = ~clk;

    video_mode_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .next_req     (next_req),
        .load_req     (load_req),
        .load_mode    (load_mode),
        .frame_start  (frame_start),
        .pll_locked   (pll_locked),
        .mode         (mode),
        .mode_change  (mode_change),
        .pll_reconfig (pll_reconfig),
        .blank        (blank),
        .busy         (busy),
        .lock_err     (lock_err)
    );

    // Short-timeout instance for the lock-failure sequence.
    video_mode_ctrl #(.LOCK_TIMEOUT(100)) dut_t (
        .clk          (clk),
        .reset_n      (reset_n),
        .next_req     (next_req),
        .load_req     (load_req),
        .load_mode    (load_mode),
        .frame_start  (frame_start),
        .pll_locked   (pll_locked),
        .mode         (t_mode),
        .mode_change  (t_mode_change),
        .pll_reconfig (t_pll_reconfig),
        .blank        (t_blank),
        .busy         (t_busy),
        .lock_err     (t_lock_err)
    );

    typedef struct {
        logic       ld;
        logic       nx;
        logic [3:0] lm;
        logic       acc;
        logic [3:0] exp_mode;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic request(input logic ld, input logic nx, input logic [3:0] lm);
        load_req  = ld;
        next_req  = nx;
        load_mode = lm;
        tick();
        load_req  = 1'b0;
        next_req  = 1'b0;
    endtask

    // Full accepted sequence on the main instance with pll_locked high.
    task automatic run_seq(input logic [3:0] exp_mode, input string nm);
        repeat (5) tick();
        pulse_frame();
        check({nm, "_blank_on"}, 32'(blank), 32'd1);
        repeat (30) tick();
        pulse_frame();
        check({nm, "_commit_mode"}, 32'(mode), 32'(exp_mode));
        check({nm, "_commit_pulse"}, {30'd0, mode_change, pll_reconfig}, 32'd3);
        tick();
        check({nm, "_pulse_single"}, 32'(mode_change), 32'd0);
        repeat (30) tick();
        pulse_frame();
        check({nm, "_settle_busy"}, {30'd0, busy, blank}, 32'd3);
        repeat (10) tick();
        pulse_frame();
        check({nm, "_release"}, {30'd0, busy, blank}, 32'd0);
        check({nm, "_final_mode"}, 32'(mode), 32'(exp_mode));
    endtask

    initial begin
        int lows;

        vecs[0] = '{1'b1, 1'b0, 4'd9,  1'b1, 4'd9, "load9"};
        vecs[1] = '{1'b0, 1'b1, 4'd0,  1'b1, 4'd0, "next_wrap"};
        vecs[2] = '{1'b1, 1'b0, 4'd12, 1'b0, 4'd0, "load_oob"};
        vecs[3] = '{1'b1, 1'b0, 4'd0,  1'b0, 4'd0, "load_same"};
        vecs[4] = '{1'b1, 1'b1, 4'd12, 1'b0, 4'd0, "load_oob_next"};
        vecs[5] = '{1'b1, 1'b1, 4'd5,  1'b1, 4'd5, "load_prio"};
        vecs[6] = '{1'b0, 1'b1, 4'd0,  1'b1, 4'd6, "next6"};
        vecs[7] = '{1'b1, 1'b0, 4'd15, 1'b0, 4'd6, "load15"};
        vecs[8] = '{1'b1, 1'b0, 4'd9,  1'b1, 4'd9, "load9b"};
        vecs[9] = '{1'b0, 1'b1, 4'd0,  1'b1, 4'd0, "next_wrap2"};

        reset_n     = 1'b0;
        next_req    = 1'b0;
        load_req    = 1'b0;
        load_mode   = 4'd0;
        frame_start = 1'b0;
        pll_locked  = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_mode", 32'(mode), 32'd0);
        check("rst_flags", {27'd0, mode_change, pll_reconfig, blank, busy, lock_err}, 32'd0);

        // Basic step 0 -> 1 with a frame every 1000 cycles.
        request(1'b0, 1'b1, 4'd0);
        check("t1_accept", {30'd0, busy, blank}, 32'd2);
        repeat (999) tick();
        pulse_frame();
        check("t1_blank_rise", 32'(blank), 32'd1);
        check("t1_mode_held", 32'(mode), 32'd0);
        lows = 0;
        for (int i = 0; i < 999; i++) begin
            if (blank !== 1'b1) lows++;
            tick();
        end
        pulse_frame();
        check("t1_commit", {27'd0, mode, mode_change}, {27'd0, 4'd1, 1'b1});
        check("t1_reconfig", 32'(pll_reconfig), 32'd1);
        for (int i = 0; i < 999; i++) begin
            if (i == 500) next_req = 1'b1;
            tick();
            next_req = 1'b0;
            if (blank !== 1'b1) lows++;
        end
        pulse_frame();
        check("t1_frame3_blank", {30'd0, busy, blank}, 32'd3);
        for (int i = 0; i < 999; i++) begin
            if (blank !== 1'b1) lows++;
            tick();
        end
        pulse_frame();
        check("t1_release", {30'd0, busy, blank}, 32'd0);
        check("t1_blank_gaps", 32'(lows), 32'd0);
        repeat (5) tick();
        check("t1_drop_not_queued", {27'd0, busy, mode}, {27'd0, 1'b0, 4'd1});

        // Request table.
        for (int v = 0; v < 10; v++) begin
            request(vecs[v].ld, vecs[v].nx, vecs[v].lm);
            check({vecs[v].name, "_busy"}, 32'(busy), 32'(vecs[v].acc));
            if (vecs[v].acc) begin
                run_seq(vecs[v].exp_mode, vecs[v].name);
            end else begin
                repeat (3) tick();
                check({vecs[v].name, "_ignored"}, {26'd0, busy, mode_change, mode},
                      {26'd0, 1'b0, 1'b0, vecs[v].exp_mode});
            end
        end

        // Earliest lock: SETTLE starts LOCK_MIN+1 cycles after mode_change.
        request(1'b0, 1'b1, 4'd0);
        repeat (5) tick();
        pulse_frame();
        repeat (5) tick();
        pulse_frame();
        check("lm_commit", {27'd0, mode, mode_change}, {27'd0, 4'd1, 1'b1});
        repeat (16) tick();
        pulse_frame();
        check("lm_frame_in_reconfig", 32'(busy), 32'd1);
        pulse_frame();
        check("lm_first_settle_frame", 32'(busy), 32'd1);
        pulse_frame();
        check("lm_release", {30'd0, busy, blank}, 32'd0);

        // Lock lost for 200 cycles after reconfig.
        request(1'b0, 1'b1, 4'd0);
        repeat (5) tick();
        pulse_frame();
        repeat (5) tick();
        pulse_frame();
        pll_locked = 1'b0;
        check("drop_commit", 32'(mode), 32'd2);
        repeat (190) tick();
        pulse_frame();
        check("drop_frame_ignored", 32'(busy), 32'd1);
        repeat (8) tick();
        pll_locked = 1'b1;
        tick();
        pulse_frame();
        check("drop_settle1", {30'd0, busy, blank}, 32'd3);
        pulse_frame();
        check("drop_release", {29'd0, busy, blank, lock_err}, 32'd0);
        check("drop_mode", 32'(mode), 32'd2);

        // Reset in BLANK.
        request(1'b0, 1'b1, 4'd0);
        repeat (5) tick();
        pulse_frame();
        check("rstmid_in_blank", 32'(blank), 32'd1);
        repeat (3) tick();
        #3 reset_n = 1'b0;
        #1;
        check("rstmid_async", {23'd0, mode, mode_change, pll_reconfig, blank, busy, lock_err},
              32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rstmid_after", {27'd0, mode_change, pll_reconfig, blank, busy, lock_err}, 32'd0);
        check("rstmid_mode", 32'(mode), 32'd0);

        // Lock timeout on the short-timeout instance: 0 -> 3, then 3 -> 4 fails.
        request(1'b1, 1'b0, 4'd3);
        run_seq(4'd3, "to_setup");
        check("to_setup_t_mode", 32'(t_mode), 32'd3);
        pll_locked = 1'b0;
        request(1'b0, 1'b1, 4'd0);
        check("to_accept", 32'(t_busy), 32'd1);
        repeat (5) tick();
        pulse_frame();
        repeat (5) tick();
        pulse_frame();
        check("to_commit", {27'd0, t_mode, t_mode_change}, {27'd0, 4'd4, 1'b1});
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (t_mode_change !== 1'b0 || t_lock_err !== 1'b0) lows++;
        end
        check("to_no_early_revert", 32'(lows), 32'd0);
        tick();
        check("to_revert_mode", 32'(t_mode), 32'd3);
        check("to_revert_pulse", {30'd0, t_mode_change, t_pll_reconfig}, 32'd3);
        check("to_lock_err", {29'd0, t_lock_err, t_busy, t_blank}, 32'd7);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (t_busy !== 1'b1 || t_blank !== 1'b1) lows++;
        end
        check("to_revert_wait", 32'(lows), 32'd0);
        tick();
        check("to_idle", {29'd0, t_busy, t_blank, t_lock_err}, 32'd1);
        check("to_idle_mode", 32'(t_mode), 32'd3);
        pll_locked = 1'b1;
        request(1'b0, 1'b1, 4'd0);
        check("to_retry_clear", {30'd0, t_busy, t_lock_err}, 32'd2);
        repeat (5) tick();
        pulse_frame();
        repeat (5) tick();
        pulse_frame();
        repeat (30) tick();
        pulse_frame();
        pulse_frame();
        check("to_retry_done", {27'd0, t_busy, t_mode}, {27'd0, 1'b0, 4'd4});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
